rally_sequencer: RTL and testbench
==================================

RALLY_SEQUENCER -- requirements
Module: rally_sequencer

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60, frames the ball is held at centre before a rally; legal range >=1.
REQ-002 SHALL have parameter POINT_FRAMES, default 30, frames the ball is frozen after a point; legal range >=1.
REQ-003 SHALL have parameter WIN_SCORE, default 5, the score that ends a match; legal range 1..2^M_SCORE_W-1.
REQ-004 SHALL have parameter M_SCORE_W, default 4, the score width.
REQ-005 SHALL have port clk_i  in  1  the single clock.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port new_frame_i  in  1  one-cycle frame strobe.
REQ-008 SHALL have port start_i  in  1  start key level; the block edge-detects it.
REQ-009 SHALL have port out_left_i  in  1  ball is past the left border; enemy scores.
REQ-010 SHALL have port out_right_i  in  1  ball is past the right border; player scores.
REQ-011 SHALL have port state_o  out  3  current state: IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4, PAUSE=5.
REQ-012 SHALL have port ball_run_o  out  1  ball datapath may advance.
REQ-013 SHALL have port ball_center_o  out  1  ball datapath holds the ball at screen centre.
REQ-014 SHALL have port paddle_en_o  out  1  paddle updates are enabled.
REQ-015 SHALL have port p_point_o / e_point_o  out  1 each  one-cycle point pulses.
REQ-016 SHALL have ports p_score_o / e_score_o  out  M_SCORE_W each  scores.
REQ-017 SHALL have port winner_o  out  1  match winner, 1=player; valid only in OVER.
REQ-018 SHALL have port serve_dir_o  out  1  next serve direction, 1=toward player.

Function
REQ-019 SHALL run all outputs from registers; each output changes on the clock edge after its qualifying input cycle.
REQ-020 SHALL go IDLE->SERVE on a start_i rising edge, clearing both scores in the same cycle.
REQ-021 SHALL, on SERVE entry, load a frame counter with SERVE_FRAMES-1; on each new_frame_i, if the counter is 0 it SHALL go to RALLY, otherwise it SHALL decrement.
REQ-022 SHALL therefore make SERVE last exactly SERVE_FRAMES frame strobes.
REQ-023 SHALL, in RALLY on out_left_i, increment e_score, pulse e_point_o, set serve_dir_o=0 and go to POINT.
REQ-024 SHALL, in RALLY on out_right_i, increment p_score, pulse p_point_o, set serve_dir_o=1 and go to POINT.
REQ-025 SHALL give out_left_i priority when out_left_i and out_right_i are asserted in the same cycle; out_right_i is then dropped.
REQ-026 SHALL ignore out_left_i and out_right_i in every state other than RALLY.
REQ-027 SHALL make POINT last exactly POINT_FRAMES strobes, using the same counter rule as SERVE.
REQ-028 SHALL, when POINT expires, go to OVER if either score equals WIN_SCORE, else go to SERVE.
REQ-029 SHALL, on OVER entry, set winner_o=1 if p_score==WIN_SCORE.
REQ-030 SHALL, in OVER on a start_i rising edge, clear the scores and winner_o and go to SERVE.
REQ-031 SHALL ignore start_i in SERVE, RALLY, POINT and PAUSE.
REQ-032 SHALL never exceed WIN_SCORE on either score; no wrap is possible.
REQ-033 SHALL drive ball_run_o=1 only in RALLY.
REQ-034 SHALL drive ball_center_o=1 in IDLE, SERVE and OVER.
REQ-035 SHALL drive paddle_en_o=1 in SERVE and RALLY.
REQ-036 SHALL hold the ball frozen in place in POINT and PAUSE (ball_run_o=0, ball_center_o=0).

Reset
REQ-037 SHALL, with rst_i high on a clock edge, force state IDLE, counter 0, scores 0, pulses 0, winner_o 0, serve_dir_o 0, ball_center_o 1, ball_run_o 0 and paddle_en_o 0.
REQ-038 SHALL reset the start-edge detector history to 1, so a key held through reset does not start a match.
REQ-039 SHALL, on reset mid-operation, abandon the current state with no point pulse.

Configuration
REQ-040 SHALL, with RALLY_SEQ_PAUSE_EN defined, add input pause_i (1 bit, edge-detected).
REQ-041 SHALL, with RALLY_SEQ_PAUSE_EN defined, go RALLY->PAUSE on a pause_i rising edge and PAUSE->RALLY on the next rising edge.
REQ-042 SHALL, with RALLY_SEQ_PAUSE_EN defined, drive paddle_en_o=0 in PAUSE and ignore out_* there.
REQ-043 SHALL, with RALLY_SEQ_PAUSE_EN undefined, omit the pause_i port and never reach PAUSE; the state encoding is unchanged.

Verification (SERVE_FRAMES=4, POINT_FRAMES=2, WIN_SCORE=3)
REQ-044 SHALL cover: reset, then start_i rising -> state_o=1; after exactly 4 new_frame_i pulses -> state_o=2, ball_run_o=1.
REQ-045 SHALL cover: out_right_i for 1 cycle in RALLY -> p_point_o one-cycle pulse, p_score_o=1, serve_dir_o=1, state_o=3; after 2 frames -> state_o=1.
REQ-046 SHALL cover: out_left_i and out_right_i in the same cycle -> e_score_o +1, p_score_o unchanged, only e_point_o pulses.
REQ-047 SHALL cover: player scoring 3 points -> after the last POINT, state_o=4, winner_o=1; start_i rising -> scores 0, state_o=1.
REQ-048 SHALL cover: start_i held high across reset release -> remains IDLE; start_i toggling during RALLY -> no state change.
REQ-049 SHALL cover, with RALLY_SEQ_PAUSE_EN: pause_i rising in RALLY -> state_o=5, out_left_i ignored; second rising edge -> state_o=2, scores unchanged.

Source files
------------

// File: rtl/rally_sequencer.sv
// Match sequencer for a two-player ball game: serve hold, rally, point freeze, game over.
// Optional pause state is built in when RALLY_SEQ_PAUSE_EN is defined.
module rally_sequencer #(
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int WIN_SCORE    = 5,
    parameter int M_SCORE_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 new_frame_i,
    input  logic                 start_i,
`ifdef RALLY_SEQ_PAUSE_EN
    input  logic                 pause_i,
`endif
    input  logic                 out_left_i,
    input  logic                 out_right_i,
    output logic [2:0]           state_o,
    output logic                 ball_run_o,
    output logic                 ball_center_o,
    output logic                 paddle_en_o,
    output logic                 p_point_o,
    output logic                 e_point_o,
    output logic [M_SCORE_W-1:0] p_score_o,
    output logic [M_SCORE_W-1:0] e_score_o,
    output logic                 winner_o,
    output logic                 serve_dir_o
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [CNT_W-1:0]     SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]     POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
    localparam logic [M_SCORE_W-1:0] WIN_VAL    = M_SCORE_W'(WIN_SCORE);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [M_SCORE_W-1:0] p_score_reg, p_score_next;
    logic [M_SCORE_W-1:0] e_score_reg, e_score_next;
    logic                 winner_reg, winner_next;
    logic                 serve_dir_reg, serve_dir_next;
    logic                 p_point_next, e_point_next;
    logic                 start_q_reg;
    logic                 start_rise;
    logic                 pause_rise;

    assign start_rise = start_i & ~start_q_reg;

`ifdef RALLY_SEQ_PAUSE_EN
    logic pause_q_reg;
    assign pause_rise = pause_i & ~pause_q_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) pause_q_reg <= 1'b1;
        else       pause_q_reg <= pause_i;
    end
`else
    assign pause_rise = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        p_score_next   = p_score_reg;
        e_score_next   = e_score_reg;
        winner_next    = winner_reg;
        serve_dir_next = serve_dir_reg;
        p_point_next   = 1'b0;
        e_point_next   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_next   = ST_SERVE;
                    cnt_next     = SERVE_LOAD;
                    p_score_next = '0;
                    e_score_next = '0;
                    winner_next  = 1'b0;
                end
            end
            ST_SERVE: begin
                if (new_frame_i) begin
                    if (cnt_reg == '0) state_next = ST_RALLY;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
            end
            ST_RALLY: begin
                // Left exit wins a simultaneous double-out.
                if (out_left_i) begin
                    state_next     = ST_POINT;
                    cnt_next       = POINT_LOAD;
                    e_score_next   = e_score_reg + 1'b1;
                    e_point_next   = 1'b1;
                    serve_dir_next = 1'b0;
                end else if (out_right_i) begin
                    state_next     = ST_POINT;
                    cnt_next       = POINT_LOAD;
                    p_score_next   = p_score_reg + 1'b1;
                    p_point_next   = 1'b1;
                    serve_dir_next = 1'b1;
                end else if (pause_rise) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_POINT: begin
                if (new_frame_i) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else if (p_score_reg == WIN_VAL || e_score_reg == WIN_VAL) begin
                        state_next  = ST_OVER;
                        winner_next = (p_score_reg == WIN_VAL);
                    end else begin
                        state_next = ST_SERVE;
                        cnt_next   = SERVE_LOAD;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_rise) state_next = ST_RALLY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath strobes are decoded from the next state so they move with state_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            p_score_reg   <= '0;
            e_score_reg   <= '0;
            winner_reg    <= 1'b0;
            serve_dir_reg <= 1'b0;
            p_point_o     <= 1'b0;
            e_point_o     <= 1'b0;
            ball_run_o    <= 1'b0;
            ball_center_o <= 1'b1;
            paddle_en_o   <= 1'b0;
            start_q_reg   <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            p_score_reg   <= p_score_next;
            e_score_reg   <= e_score_next;
            winner_reg    <= winner_next;
            serve_dir_reg <= serve_dir_next;
            p_point_o     <= p_point_next;
            e_point_o     <= e_point_next;
            ball_run_o    <= (state_next == ST_RALLY);
            ball_center_o <= (state_next == ST_IDLE) || (state_next == ST_SERVE) ||
                             (state_next == ST_OVER);
            paddle_en_o   <= (state_next == ST_SERVE) || (state_next == ST_RALLY);
            start_q_reg   <= start_i;
        end
    end

    assign state_o     = state_reg;
    assign p_score_o   = p_score_reg;
    assign e_score_o   = e_score_reg;
    assign winner_o    = winner_reg;
    assign serve_dir_o = serve_dir_reg;

endmodule

// File: tb/tb_rally_sequencer.sv
// Directed bench for rally_sequencer with SERVE_FRAMES=4, POINT_FRAMES=2, WIN_SCORE=3.
module tb_rally_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_frame = 1'b0;
    logic       start = 1'b0;
    logic       out_left = 1'b0;
    logic       out_right = 1'b0;
    logic [2:0] state;
    logic       ball_run, ball_center, paddle_en, p_point, e_point, winner, serve_dir;
    logic [3:0] p_score, e_score;
`ifdef RALLY_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    rally_sequencer #(
        .SERVE_FRAMES(4),
        .POINT_FRAMES(2),
        .WIN_SCORE(3),
        .M_SCORE_W(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .new_frame_i(new_frame),
        .start_i(start),
`ifdef RALLY_SEQ_PAUSE_EN
        .pause_i(pause),
`endif
        .out_left_i(out_left),
        .out_right_i(out_right),
        .state_o(state),
        .ball_run_o(ball_run),
        .ball_center_o(ball_center),
        .paddle_en_o(paddle_en),
        .p_point_o(p_point),
        .e_point_o(e_point),
        .p_score_o(p_score),
        .e_score_o(e_score),
        .winner_o(winner),
        .serve_dir_o(serve_dir)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            tick();
            new_frame = 1'b0;
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with start held high; release must not start a match.
        start = 1'b1;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_center", ball_center, 1);
        check("rst_run", ball_run, 0);
        check("rst_paddle", paddle_en, 0);
        check("rst_scores", {p_score, e_score}, 0);
        check("rst_dir", serve_dir, 0);
        rst = 1'b0;
        tick(); tick();
        check("held_start_idle", state, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        $display("txn start: state=%0d", state);
        check("start_serve", state, 1);
        check("serve_paddle", paddle_en, 1);
        check("serve_center", ball_center, 1);

        out_left = 1'b1;
        tick();
        out_left = 1'b0;
        check("serve_ignores_out", e_score, 0);

        frames(3);
        check("serve_3frames", state, 1);
        frames(1);
        $display("txn serve done: state=%0d run=%0d", state, ball_run);
        check("rally_state", state, 2);
        check("rally_run", ball_run, 1);
        check("rally_center", ball_center, 0);

        start = 1'b1; tick();
        start = 1'b0; tick();
        check("rally_ignores_start", state, 2);

        out_right = 1'b1;
        tick();
        out_right = 1'b0;
        $display("txn right out: p=%0d pp=%0d state=%0d", p_score, p_point, state);
        check("p_point_pulse", p_point, 1);
        check("p_score_1", p_score, 1);
        check("serve_dir_1", serve_dir, 1);
        check("point_state", state, 3);
        check("point_run", ball_run, 0);
        check("point_center", ball_center, 0);
        tick();
        check("p_point_one_cycle", p_point, 0);
        frames(1);
        check("point_1frame", state, 3);
        frames(1);
        check("point_to_serve", state, 1);

        frames(4);
        out_left = 1'b1;
        out_right = 1'b1;
        tick();
        out_left = 1'b0;
        out_right = 1'b0;
        $display("txn double out: p=%0d e=%0d", p_score, e_score);
        check("both_e_score", e_score, 1);
        check("both_p_score", p_score, 1);
        check("both_e_point", e_point, 1);
        check("both_p_point", p_point, 0);
        check("both_dir", serve_dir, 0);

        frames(2);
        frames(4);
        out_right = 1'b1; tick(); out_right = 1'b0;
        check("p_score_2", p_score, 2);
        frames(2);
        frames(4);
        out_right = 1'b1; tick(); out_right = 1'b0;
        check("p_score_3", p_score, 3);
        frames(2);
        $display("txn match end: state=%0d winner=%0d", state, winner);
        check("over_state", state, 4);
        check("over_winner", winner, 1);
        check("over_center", ball_center, 1);
        check("over_paddle", paddle_en, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        $display("txn restart: state=%0d p=%0d e=%0d", state, p_score, e_score);
        check("restart_state", state, 1);
        check("restart_scores", {p_score, e_score}, 0);
        check("restart_winner", winner, 0);

        // Reset mid-rally together with an out: no point may be recorded.
        frames(4);
        rst = 1'b1;
        out_right = 1'b1;
        tick();
        out_right = 1'b0;
        $display("txn mid reset: state=%0d pp=%0d", state, p_point);
        check("midrst_state", state, 0);
        check("midrst_point", p_point, 0);
        check("midrst_score", p_score, 0);
        rst = 1'b0;
        tick();

`ifdef RALLY_SEQ_PAUSE_EN
        start = 1'b1; tick(); start = 1'b0;
        frames(4);
        pause = 1'b1; tick(); pause = 1'b0;
        check("pause_state", state, 5);
        check("pause_paddle", paddle_en, 0);
        out_left = 1'b1; tick(); out_left = 1'b0;
        check("pause_ignores_out", e_score, 0);
        pause = 1'b1; tick(); pause = 1'b0;
        check("unpause_state", state, 2);
        check("unpause_scores", {p_score, e_score}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
